// File: rtl/keyboard_event_tracker.sv
// Set-2 PS/2 scancode decoder that tracks a configurable key table. It produces
// held/pulse bitmaps, a priority key number and a make/break event FIFO.
module keyboard_event_tracker #(
  parameter int NUM_KEYS = 14,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {
    9'h05A, 9'h029, 9'h172, 9'h175, 9'h174, 9'h16B, 9'h04B,
    9'h042, 9'h03B, 9'h033, 9'h02B, 9'h023, 9'h01B, 9'h01C},
  parameter int FIFO_DEPTH = 8,
  parameter int PULSE_OR_HOLD = 0,
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int KN_W = $clog2(NUM_KEYS + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [KN_W-1:0]     key_num,
  output logic                evt_valid,
  output logic [IDX_W:0]      evt_data,
  input  logic                evt_ready,
  output logic                evt_overflow,
  input  logic                ovf_clear
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_MAKE, S_BREAK, S_EXT_MAKE, S_EXT_BREAK, S_PAUSE} state_t;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_pause_cnt, w_pause_nxt;
  logic                 w_is_make, w_is_break, w_ext, w_bat;
  logic [NUM_KEYS-1:0]  w_match, w_new_make, w_new_brk;
  logic [NUM_KEYS-1:0]  r_held, r_pulse, r_pend_make, r_pend_brk;
  logic [NUM_KEYS-1:0]  w_pm, w_pb, w_onehot, w_kn_src;
  logic                 w_push, w_sel_make;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [IDX_W:0]       w_push_data;

  logic [IDX_W:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]       r_count;
  logic [IDX_W:0]       r_last, w_head;
  logic                 w_empty, w_full, w_pop, w_push_ok, w_drop;
  logic                 r_ovf;

  // Decoder: classify the byte by current prefix state
  always_comb begin
    w_state_nxt = r_state;
    w_pause_nxt = r_pause_cnt;
    w_is_make   = 1'b0;
    w_is_break  = 1'b0;
    w_ext       = 1'b0;
    w_bat       = 1'b0;
    if (byte_valid) begin
      case (r_state)
        S_MAKE: begin
          if (byte_data == 8'hE0)      w_state_nxt = S_EXT_MAKE;
          else if (byte_data == 8'hF0) w_state_nxt = S_BREAK;
          else if (byte_data == 8'hE1) begin
            w_state_nxt = S_PAUSE;
            w_pause_nxt = 3'd7;
          end
          else if (byte_data == 8'hAA || byte_data == 8'h00 || byte_data == 8'hFF)
            w_bat = 1'b1;
          else w_is_make = 1'b1;
        end
        S_BREAK: begin
          w_is_break  = 1'b1;
          w_state_nxt = S_MAKE;
        end
        S_EXT_MAKE: begin
          if (byte_data == 8'hF0)      w_state_nxt = S_EXT_BREAK;
          else if (byte_data != 8'hE0) begin
            w_is_make   = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = S_MAKE;
          end
        end
        S_EXT_BREAK: begin
          w_is_break  = 1'b1;
          w_ext       = 1'b1;
          w_state_nxt = S_MAKE;
        end
        S_PAUSE: begin
          w_pause_nxt = r_pause_cnt - 3'd1;
          if (r_pause_cnt <= 3'd1) begin
            w_pause_nxt = 3'd0;
            w_state_nxt = S_MAKE;
          end
        end
        default: w_state_nxt = S_MAKE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++)
      w_match[i] = (KEY_CODES[9*i +: 9] == {w_ext, byte_data});
  end

  assign w_new_make = w_is_make  ? (w_match & ~r_held) : '0;
  assign w_new_brk  = w_is_break ? (w_match &  r_held) : '0;

  // New events join the pending sets so the first one can be pushed this cycle
  assign w_pm       = r_pend_make | w_new_make;
  assign w_pb       = r_pend_brk  | w_new_brk;
  assign w_sel_make = |w_pm;
  assign w_push     = w_sel_make | (|w_pb);
  assign w_sel_idx  = lowest_idx(w_sel_make ? w_pm : w_pb);
  assign w_push_data = {w_sel_make, w_sel_idx};

  always_comb begin
    w_onehot = '0;
    w_onehot[w_sel_idx] = 1'b1;
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  assign w_pop     = !w_empty && evt_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_MAKE;
      r_pause_cnt <= '0;
      r_held      <= '0;
      r_pulse     <= '0;
      r_pend_make <= '0;
      r_pend_brk  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last      <= '0;
      r_ovf       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pause_cnt <= w_pause_nxt;
      r_held      <= w_bat ? '0 : ((r_held | w_new_make) & ~w_new_brk);
      r_pulse     <= w_new_make;
      r_pend_make <= w_sel_make ? (w_pm & ~w_onehot) : w_pm;
      r_pend_brk  <= w_sel_make ? w_pb : (w_pb & ~w_onehot);
      if (!w_empty) r_last <= w_head;
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
      // A drop in the same cycle as a clear leaves the flag set
      if (w_drop)         r_ovf <= 1'b1;
      else if (ovf_clear) r_ovf <= 1'b0;
    end
  end

  assign w_kn_src = (PULSE_OR_HOLD != 0) ? r_pulse : r_held;

  always_comb begin
    key_num = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (w_kn_src[i]) key_num = KN_W'(i + 1);
  end

  assign key_held     = r_held;
  assign key_pulse    = r_pulse;
  assign evt_valid    = !w_empty;
  assign evt_data     = w_empty ? r_last : w_head;
  assign evt_overflow = r_ovf;

endmodule

// File: tb/tb_keyboard_event_tracker.sv
// Directed bench for keyboard_event_tracker using the default 14-key table.
module tb_keyboard_event_tracker;

  logic        clock = 1'b0;
  logic        reset, byte_valid, evt_ready, ovf_clear;
  logic [7:0]  byte_data;
  logic [13:0] key_held, key_pulse;
  logic [3:0]  key_num;
  logic        evt_valid, evt_overflow;
  logic [4:0]  evt_data;

  int n_vec = 0;
  int n_err = 0;

  keyboard_event_tracker dut (
    .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .key_held(key_held), .key_pulse(key_pulse), .key_num(key_num),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .evt_overflow(evt_overflow), .ovf_clear(ovf_clear)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic expect_evt(input string tag, input logic [4:0] exp);
    chk({tag, "_valid"}, evt_valid, 1);
    chk(tag, evt_data, exp);
    evt_ready = 1'b1;
    @(negedge clock);
    evt_ready = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq [8];
    reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00;
    evt_ready = 1'b0; ovf_clear = 1'b0;
    do_reset();
    chk("rst_held", key_held, 0);
    chk("rst_pulse", key_pulse, 0);
    chk("rst_num", key_num, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_ovf", evt_overflow, 0);
    chk("rst_data", evt_data, 0);

    // A make then break
    send_byte(8'h1C);
    chk("a_held", key_held, 14'h0001);
    chk("a_pulse", key_pulse, 14'h0001);
    chk("a_num", key_num, 1);
    @(negedge clock);
    chk("a_pulse_gone", key_pulse, 0);
    chk("a_num_hold", key_num, 1);
    expect_evt("a_make", 5'h10);
    chk("a_empty", evt_valid, 0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("a_rel_held", key_held, 0);
    chk("a_rel_num", key_num, 0);
    expect_evt("a_break", 5'h00);

    // Extended Left vs non-extended 6B
    send_byte(8'hE0);
    send_byte(8'h6B);
    chk("left_held", key_held, 14'h0100);
    chk("left_num", key_num, 9);
    send_byte(8'h6B);
    chk("nonext_6b", key_held, 14'h0100);
    expect_evt("left_make", 5'h18);
    chk("left_one_evt", evt_valid, 0);
    idle(2);
    chk("data_holds", evt_data, 5'h18);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    chk("left_rel", key_held, 0);
    expect_evt("left_break", 5'h08);

    // Typematic repeat
    send_byte(8'h1C);
    chk("typ_pulse0", key_pulse, 14'h0001);
    for (int i = 0; i < 4; i++) begin
      idle(3);
      send_byte(8'h1C);
      chk("typ_pulse", key_pulse, 0);
      chk("typ_held", key_held, 14'h0001);
    end
    expect_evt("typ_make", 5'h10);
    chk("typ_one_evt", evt_valid, 0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    expect_evt("typ_break", 5'h00);

    // Overflow: 8 makes fill the FIFO, break of A is dropped
    seq = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h33, 8'h3B, 8'h42, 8'h4B};
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    chk("ovf_before", evt_overflow, 0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    idle(1);
    chk("ovf_set", evt_overflow, 1);
    chk("ovf_held", key_held, 14'h00FE);
    for (int i = 0; i < 8; i++) expect_evt("ovf_pop", 5'(16 + i));
    chk("ovf_drained", evt_valid, 0);
    chk("ovf_sticky", evt_overflow, 1);
    @(negedge clock);
    ovf_clear = 1'b1;
    @(negedge clock);
    ovf_clear = 1'b0;
    chk("ovf_clear", evt_overflow, 0);
    do_reset();
    chk("rst2_held", key_held, 0);

    // Pause sequence is skipped
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    idle(1);
    chk("pause_held", key_held, 0);
    chk("pause_evt", evt_valid, 0);
    send_byte(8'h1C);
    chk("post_pause", key_held, 14'h0001);
    expect_evt("post_pause_evt", 5'h10);

    // BAT clears held keys silently
    send_byte(8'h23);
    chk("ad_held", key_held, 14'h0005);
    chk("ad_num", key_num, 1);
    expect_evt("d_make", 5'h12);
    send_byte(8'hAA);
    chk("bat_held", key_held, 0);
    chk("bat_pulse", key_pulse, 0);
    idle(1);
    chk("bat_evt", evt_valid, 0);

    // Reset mid extended break
    send_byte(8'hE0);
    send_byte(8'hF0);
    do_reset();
    send_byte(8'h6B);
    idle(1);
    chk("midrst_held", key_held, 0);
    chk("midrst_evt", evt_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keyboard_event_tracker.md
Name: keyboard_event_tracker

Overview:
Parametrised successor to the fixed 14-key tracker. It consumes the PS/2 byte stream (received_data / received_data_en from PS2_Controller) and decodes set-2 make, break, E0-extended and E1-pause sequences against a configurable key table. It outputs a per-key held bitmap, one-cycle press pulses, a priority-encoded key number compatible with the old keypress_out, and a make/break event FIFO with a valid/ready handshake. It sits between PS2_Controller and game control logic.

Parameters:
NUM_KEYS, 14, number of tracked keys (1..64).
KEY_CODES, 14-entry default table, packed NUM_KEYS*9 bits; entry i = bits [9i+8:9i]; bit 8 = E0-extended, bits 7:0 = scancode. Default order i=0..13: A 0x01C, S 0x01B, D 0x023, F 0x02B, H 0x033, J 0x03B, K 0x042, L 0x04B, Left 0x16B, Right 0x174, Up 0x175, Down 0x172, Space 0x029, Enter 0x05A.
FIFO_DEPTH, 8, event FIFO entries; must be a power of 2, at least 2.
PULSE_OR_HOLD, 0, selects key_num source: 0 = held bitmap, 1 = pulse bitmap.
Derived: IDX_W = max(1, clog2(NUM_KEYS)); KN_W = clog2(NUM_KEYS+1).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
byte_valid  in  1  one-cycle strobe; new scancode byte available
byte_data  in  8  scancode byte
key_held  out  NUM_KEYS  bit i high while key i is down
key_pulse  out  NUM_KEYS  bit i high for exactly one cycle on key i's 0->1 transition
key_num  out  KN_W  lowest active index + 1 (source per PULSE_OR_HOLD); 0 = none
evt_valid  out  1  FIFO non-empty
evt_data  out  IDX_W+1  [IDX_W] = 1 make / 0 break; [IDX_W-1:0] = key index
evt_ready  in  1  consumer pops the head when evt_valid && evt_ready
evt_overflow  out  1  sticky; an event was dropped because the FIFO was full
ovf_clear  in  1  clears evt_overflow; a drop in the same cycle wins

Behaviour:
- Reset clears all outputs and state to 0: decoder returns to MAKE, FIFO is empty, the pause counter is 0. Reset takes priority over every input in the same cycle.
- Decoder states:
  - MAKE: E0 -> EXT_MAKE; F0 -> BREAK; E1 -> PAUSE_SKIP with count 7; 0xAA, 0x00 or 0xFF (BAT/overrun) clears key_held with no events and no pulses; any other byte is matched as a non-extended make, then stays in MAKE.
  - BREAK: the byte is matched as a non-extended break -> MAKE.
  - EXT_MAKE: F0 -> EXT_BREAK; E0 stays; any other byte is matched as an extended make -> MAKE.
  - EXT_BREAK: the byte is matched as an extended break -> MAKE.
  - PAUSE_SKIP: decrement the count on each byte; return to MAKE once the count reaches 0. No matching happens here.
- Decoder state changes only on cycles with byte_valid.
- Matching compares every table entry in parallel on {ext, byte}; every matching entry updates.
- Make on a key not held: set key_held[i], key_pulse[i] = 1 on the next cycle, push a make event.
- Make on a key already held (typematic repeat): no change, no pulse, no event.
- Break on a held key: clear key_held[i], push a break event. Break on a key not held: ignored.
- Unmatched codes are ignored.
- Latency: byte_valid at cycle N -> key_held, key_pulse and key_num update at N+1. A pushed event has evt_valid high at N+1 if the FIFO was empty.
- key_pulse is registered and cleared every cycle unless set again.
- If multiple table entries match one byte, all of them update and events are pushed lowest index first. Push capacity is 1 event per cycle, so extra events spill to the following cycles through a per-key pending bitmap. A new byte_valid never arrives within NUM_KEYS cycles, because the PS/2 byte period is far longer.
- key_num is combinational from the registered bitmaps, lowest index has priority: key_num = i+1.
- FIFO:
  - Push is accepted if not full, or if full and a pop occurs the same cycle.
  - A push while full with no pop drops the new event, sets evt_overflow, and leaves the contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH. evt_data shows the head while evt_valid is high; with evt_valid low, evt_data holds its last value.
  - Pop when empty is a no-op.

Test Plan:
- Reset, then bytes 1C -> key_held[0]=1, key_pulse=0x0001 for 1 cycle, key_num=1, event {1,0}. Then F0 1C -> key_held=0, event {0,0}, key_num=0.
- E0 6B (Left), then 6B (A-table non-extended miss) -> key_held[8]=1 only, key_num=9, one make event idx 8. Then E0 F0 6B -> key_held[8]=0 and a break event.
- 1C sent 5x (typematic) with evt_ready=0 -> exactly 1 make event and 1 pulse; key_held[0] stays 1.
- evt_ready=0, 9 distinct make/break transitions with FIFO_DEPTH=8 -> 8 events held in order, 9th dropped, evt_overflow=1. Pop all -> original order; ovf_clear -> 0.
- E1 14 77 E1 F0 14 F0 77 (pause) -> no key_held change and no events. A following 1C decodes as a normal make.
- Hold A and D, send AA -> key_held=0, no events. Assert reset mid E0 F0 sequence (after E0 F0), then send 6B -> decoded as a non-extended make: no match, no change.
